// File: rtl/flit_injector_if.sv
// Bundles the two flit paths of the injector: the upstream test source and the router port.
interface flit_injector_if #(
  parameter int DATA_W = 8
);
  logic              src_en;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              credit_in;

  modport master (
    output src_en,
    output out_data,
    output out_valid,
    input  in_data,
    input  in_valid,
    input  credit_in
  );

  modport slave (
    input  src_en,
    input  out_data,
    input  out_valid,
    output in_data,
    output in_valid,
    output credit_in
  );
endinterface

// File: rtl/flit_injector.sv
// Credit-based flit injector: buffers source flits in a small FIFO and forwards them while
// the router has free slots, counting sent and dropped flits.
module flit_injector #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int CREDITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  flit_injector_if.master       bus,
  output logic [15:0]           sent_cnt,
  output logic [7:0]            drop_cnt,
  output logic                  credit_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CREDITS) + 1;
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   SRC_LIM  = (AW+1)'(DEPTH - 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [CW-1:0]     credit;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;

  always_comb begin
    full = (count == FULL_LVL);
    pop  = (count != '0) && (credit != '0);
    push = bus.in_valid && (!full || pop);
    drop = bus.in_valid && full && !pop;
  end

  // The source answers one cycle late, so stop asking while one slot is still free.
  assign bus.src_en    = rst && run && (count < SRC_LIM);
  assign bus.out_valid = pop;
  assign bus.out_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      credit     <= CRED_MAX;
      sent_cnt   <= '0;
      drop_cnt   <= '0;
      credit_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        sent_cnt <= sent_cnt + 16'd1;
      end
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (drop) drop_cnt <= sat_inc8(drop_cnt);
      // A returned credit and a consumed one cancel out.
      if (bus.credit_in && !pop) begin
        if (credit == CRED_MAX) credit_err <= 1'b1;
        else                    credit <= credit + 1'b1;
      end else if (pop && !bus.credit_in) begin
        credit <= credit - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_flit_injector.sv
// Directed bench for flit_injector with a queue-based reference model checked every cycle.
module tb_flit_injector;
  localparam int DATA_W  = 8;
  localparam int DEPTH   = 4;
  localparam int CREDITS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [15:0] sent_cnt;
  logic [7:0]  drop_cnt;
  logic        credit_err;

  flit_injector_if #(.DATA_W(DATA_W)) bus ();

  flit_injector #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CREDITS(CREDITS)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .bus        (bus),
    .sent_cnt   (sent_cnt),
    .drop_cnt   (drop_cnt),
    .credit_err (credit_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a plain queue plus credit and event counters.
  int unsigned mq[$];
  int          mcred;
  int          msent;
  int          mdrop;
  bit          merr;
  bit          mpop;

  initial begin
    mcred = CREDITS; msent = 0; mdrop = 0; merr = 0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        mq.delete();
        mcred = CREDITS; msent = 0; mdrop = 0; merr = 0;
      end else begin
        mpop = (mq.size() > 0) && (mcred > 0);
        if (mpop) begin
          void'(mq.pop_front());
          msent = (msent + 1) % 65536;
        end
        if (bus.in_valid) begin
          if (mq.size() < DEPTH) mq.push_back(int'(bus.in_data));
          else if (mdrop < 255) mdrop++;
        end
        if (bus.credit_in && !mpop) begin
          if (mcred == CREDITS) merr = 1;
          else mcred++;
        end else if (mpop && !bus.credit_in) begin
          mcred--;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  bit exp_v;
  initial begin
    forever begin
      @(negedge clk);
      exp_v = (mq.size() > 0) && (mcred > 0);
      chk("m_out_valid", bus.out_valid, exp_v);
      if (exp_v) chk("m_out_data", bus.out_data, mq[0]);
      chk("m_src_en", bus.src_en, rst && run && (mq.size() < DEPTH - 1));
      chk("m_sent_cnt", sent_cnt, msent);
      chk("m_drop_cnt", drop_cnt, mdrop);
      chk("m_credit_err", credit_err, merr);
    end
  end

  // Stimulus helpers: a one-cycle-latency source and a credit return two cycles after a transfer.
  bit          src_on;
  bit          auto_cr;
  int          src_left;
  logic [7:0]  src_val;
  bit          en_last;
  bit [1:0]    hist;
  logic [7:0]  cap[$];
  logic [15:0] s;

  task automatic tick();
    @(negedge clk);
    en_last = bus.src_en;
    hist = {hist[0], bus.out_valid};
    if (bus.out_valid) cap.push_back(bus.out_data);
    @(posedge clk);
    #1;
    if (src_on) begin
      bus.in_valid = en_last && (src_left > 0);
      bus.in_data  = src_val;
      if (bus.in_valid) begin
        src_val++;
        src_left--;
      end
    end
    if (auto_cr) bus.credit_in = hist[1];
  endtask

  task automatic do_reset();
    rst = 1'b0;
    hist = '0;
    tick();
    tick();
    rst = 1'b1;
    hist = '0;
    cap.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.credit_in = 1'b0;
    run = 1'b1; rst = 1'b1;
    src_on = 0; auto_cr = 0; src_left = 0; src_val = '0; en_last = 0; hist = '0;
    #1 rst = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_src_en", bus.src_en, 0);
    chk("rst_sent", sent_cnt, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_err", credit_err, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Streaming with credits returned two cycles after each transfer.
    src_on = 1; src_left = 10; src_val = 8'h01; auto_cr = 1; hist = '0; cap.delete();
    repeat (40) tick();
    chk("stream_sent", sent_cnt, 10);
    chk("stream_drop", drop_cnt, 0);
    chk("stream_len", cap.size(), 10);
    for (int i = 0; i < cap.size() && i < 10; i++) chk("stream_data", cap[i], i + 1);

    // Credit starvation: four transfers, then the FIFO fills and src_en closes.
    src_on = 0; auto_cr = 0; bus.credit_in = 0; bus.in_valid = 0;
    do_reset();
    src_on = 1; src_left = 100; src_val = 8'h11; run = 1;
    repeat (15) tick();
    chk("starve_sent", sent_cnt, 4);
    chk("starve_out_valid", bus.out_valid, 0);
    chk("starve_src_en", bus.src_en, 0);
    chk("starve_drop", drop_cnt, 0);
    chk("starve_first", cap[0], 8'h11);

    // Drain one credit at a time with run low, leaving zero credits and an empty FIFO.
    run = 0; src_on = 0; bus.in_valid = 0;
    for (int k = 0; k < 20 && mq.size() > 0; k++) begin
      bus.credit_in = 1; tick();
      bus.credit_in = 0; tick();
    end
    chk("drain_sent", sent_cnt, 8);

    // Forced overflow: six flits into an empty FIFO with no credits.
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1; bus.in_data = 8'(8'hA1 + i);
      tick();
    end
    bus.in_valid = 0;
    tick();
    chk("ovf_drop", drop_cnt, 2);
    chk("ovf_out_valid", bus.out_valid, 0);
    chk("ovf_sent", sent_cnt, 8);

    // Push, pop and credit return together on a full FIFO.
    bus.credit_in = 1; tick();
    chk("sim_pre_valid", bus.out_valid, 1);
    chk("sim_pre_data", bus.out_data, 8'hA1);
    s = sent_cnt;
    bus.in_valid = 1; bus.in_data = 8'hB0;
    tick();
    bus.in_valid = 0; bus.credit_in = 0;
    chk("sim_sent", sent_cnt, 16'(s + 16'd1));
    chk("sim_valid", bus.out_valid, 1);
    chk("sim_head", bus.out_data, 8'hA2);
    chk("sim_drop", drop_cnt, 2);
    cap.delete(); hist = '0; auto_cr = 1;
    repeat (20) tick();
    auto_cr = 0; bus.credit_in = 0;
    chk("sim_order_len", cap.size(), 4);
    if (cap.size() == 4) begin
      chk("sim_order0", cap[0], 8'hA2);
      chk("sim_order1", cap[1], 8'hA3);
      chk("sim_order2", cap[2], 8'hA4);
      chk("sim_order3", cap[3], 8'hB0);
    end

    // Spurious credit with the counter already full.
    do_reset();
    chk("err_clear", credit_err, 0);
    bus.credit_in = 1; tick();
    bus.credit_in = 0;
    chk("err_set", credit_err, 1);
    repeat (3) tick();
    chk("err_sticky", credit_err, 1);
    bus.in_valid = 1; bus.in_data = 8'h5A; tick();
    bus.in_valid = 0;
    chk("err_flit_valid", bus.out_valid, 1);
    chk("err_flit_data", bus.out_data, 8'h5A);
    tick();
    chk("err_flit_sent", sent_cnt, 1);

    // Reset in the middle of a stream with three flits buffered.
    do_reset();
    run = 1; src_on = 1; src_left = 100; src_val = 8'h31;
    repeat (15) tick();
    run = 0; src_on = 0; bus.in_valid = 0;
    bus.credit_in = 1; tick(); tick();
    bus.credit_in = 0;
    chk("mid_pre_valid", bus.out_valid, 1);
    chk("mid_pre_data", bus.out_data, 8'h36);
    chk("mid_pre_sent", sent_cnt, 5);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_src_en", bus.src_en, 0);
    chk("mid_rst_sent", sent_cnt, 0);
    chk("mid_rst_drop", drop_cnt, 0);
    tick();
    rst = 1'b1; cap.delete(); hist = '0;
    run = 1; src_on = 1; src_left = 3; src_val = 8'hC1; auto_cr = 1;
    repeat (10) tick();
    chk("mid_post_len", cap.size(), 3);
    if (cap.size() > 0) chk("mid_post_first", cap[0], 8'hC1);
    chk("mid_post_sent", sent_cnt, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flit_injector.md
FLIT_INJECTOR -- requirements
Module: flit_injector

Interface
REQ-001 Parameter DATA_W, default 8, flit width in bits.
REQ-002 Parameter DEPTH, default 4, FIFO entries; power of two, minimum 2.
REQ-003 Parameter CREDITS, default 4, downstream buffer slots; minimum 1.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 run  input  1  injection enable from the testbench/controller.
REQ-007 src_en  output  1  enable to the upstream test source; that source returns one flit one cycle after each asserted cycle.
REQ-008 in_data  input  DATA_W  flit from the upstream source.
REQ-009 in_valid  input  1  in_data valid this cycle; the source has no backpressure.
REQ-010 out_data  output  DATA_W  flit toward the router port.
REQ-011 out_valid  output  1  out_data presented; the transfer occurs in this cycle.
REQ-012 credit_in  input  1  one-cycle pulse; the router freed one slot.
REQ-013 sent_cnt  output  16  flits transferred, wraps at 2^16.
REQ-014 drop_cnt  output  8  flits dropped on overflow, saturates at 255.
REQ-015 credit_err  output  1  sticky flag: credit returned with the counter already at CREDITS.

Function
REQ-016 The block SHALL hold a DEPTH-entry FIFO with occupancy count 0..DEPTH, read and write pointers that wrap modulo DEPTH, and first-in first-out ordering.
REQ-017 src_en SHALL equal run AND (count < DEPTH-1), using the registered count; this covers the source's one-cycle latency.
REQ-018 When in_valid=1 and the FIFO is not full (or is full with a pop in the same cycle), in_data SHALL be written at the edge.
REQ-019 When in_valid=1, the FIFO is full and no pop occurs, the flit SHALL be dropped and drop_cnt incremented, saturating at 255.
REQ-020 out_valid SHALL be combinational: (count > 0) AND (credit counter > 0). out_data SHALL be the head entry; its value is don't-care when out_valid=0.
REQ-021 Each cycle with out_valid=1 SHALL pop the head, decrement the credit counter and increment sent_cnt.
REQ-022 The credit counter SHALL reset to CREDITS. A credit_in alone SHALL increment it; a credit_in together with a pop SHALL leave it unchanged.
REQ-023 A credit_in with the counter at CREDITS and no pop SHALL leave the counter at CREDITS and set credit_err.
REQ-024 A simultaneous push and pop SHALL leave count unchanged, including at count=DEPTH; push into an empty FIFO SHALL first present on the following cycle.
REQ-025 run=0 SHALL NOT stop draining; only src_en is gated.
REQ-026 Arithmetic SHALL NOT overflow: count needs clog2(DEPTH)+1 bits; the credit counter needs clog2(CREDITS)+1 bits.

Reset
REQ-027 While rst=0, count, both pointers, sent_cnt, drop_cnt and credit_err SHALL be 0 and the credit counter SHALL be CREDITS, so out_valid=0 and src_en=0, asynchronously.
REQ-028 Asserting rst mid-operation SHALL discard all FIFO contents; no flit present before reset SHALL appear after it.
REQ-029 Operation SHALL resume on the first rising edge after rst rises; FIFO storage contents need not be reset.

Verification
REQ-030 Stream: DEPTH=4, CREDITS=4, run=1, a credit_in pulse two cycles after each transfer, source data 0x01..0x0A -> out_data 0x01..0x0A in order, sent_cnt=10, drop_cnt=0.
REQ-031 Credit starvation: no credit_in pulses -> exactly 4 transfers; out_valid then stays 0; src_en drops to 0 when count reaches 3; drop_cnt=0.
REQ-032 Forced overflow: force in_valid=1 for 6 cycles with no credits and the FIFO empty at the start -> 4 flits stored, drop_cnt=2, stored order preserved.
REQ-033 Simultaneous events: count=4 with a push, a pop and credit_in in the same cycle -> count stays 4, credit counter unchanged, sent_cnt+1.
REQ-034 Credit error: credit_in with the counter at 4 and no pop -> credit_err=1 and stays 1 until reset; counter stays 4.
REQ-035 Reset mid-stream: rst=0 with count=3 -> out_valid=0 immediately; after release the first output is the first post-reset input flit, and the counters are 0.
